id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection. It captures

---
 rtl/id_ex_stage_reg.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for EX and inserts one bubble when the ID
// instruction reads the destination of a load that is currently in EX.
// Flush kills the ID instruction, and hold freezes the stage. Two saturating
// counters record bubbles inserted and valid instructions flushed.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_uses_rs1_en,
  input  logic              id_uses_rs2_en,
  input  logic [4:0]        id_rd_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic              id_reg_write_en,
  input  logic              id_mem_read_en,
  input  logic              id_mem_write_en,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic              ex_reg_write_en,
  output logic              ex_mem_read_en,
  output logic              ex_mem_write_en,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_if_id_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load in EX whose nonzero rd is read by the valid ID instruction.
  always_comb begin
    load_use = valid_q & mem_read_q & reg_write_q & (rd_q != 5'd0) & id_valid_i &
               ((id_uses_rs1_en & (id_rs1_i == rd_q)) |
                (id_uses_rs2_en & (id_rs2_i == rd_q)));
    stall_if_id_o = load_use & ~flush_i & ~hold_i;
  end

  // Next-state selection: hold > flush > load-use bubble > capture.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!hold_i) begin
      if (flush_i || load_use) begin
        // Bubble: data fields keep stale values, but nothing downstream may act on them.
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (flush_i) begin
          if (id_valid_i) flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
          bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
      end else begin
        valid_d     = id_valid_i;
        pc_d        = id_pc_i;
        rs1_d       = id_rs1_i;
        rs2_d       = id_rs2_i;
        rd_d        = id_rd_i;
        rs1_data_d  = id_rs1_data_i;
        rs2_data_d  = id_rs2_data_i;
        imm_d       = id_imm_i;
        reg_write_d = id_reg_write_en & id_valid_i;
        mem_read_d  = id_mem_read_en & id_valid_i;
        mem_write_d = id_mem_write_en & id_valid_i;
        ctrl_d      = id_ctrl_i;
      end
    end
  end

  // Stage register with synchronous reset clearing every EX field and counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_pc_o         = pc_q;
  assign ex_rs1_o        = rs1_q;
  assign ex_rs2_o        = rs2_q;
  assign ex_rd_o         = rd_q;
  assign ex_rs1_data_o   = rs1_data_q;
  assign ex_rs2_data_o   = rs2_data_q;
  assign ex_imm_o        = imm_q;
  assign ex_reg_write_en = reg_write_q;
  assign ex_mem_read_en  = mem_read_q;
  assign ex_mem_write_en = mem_write_q;
  assign ex_ctrl_o       = ctrl_q;
  assign bubble_cnt_o    = bubble_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, counter saturation and
// reset-mid-stall sequence, then a random instruction stream against a model.
module tb_id_ex_stage_reg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk_i, rst_i, id_valid_i, id_uses_rs1_en, id_uses_rs2_en;
  logic id_reg_write_en, id_mem_read_en, id_mem_write_en, flush_i, hold_i;
  logic [XLEN-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic ex_valid_o, ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, stall_if_id_o;
  logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0] bubble_cnt_o, flush_cnt_o;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_en(id_uses_rs1_en), .id_uses_rs2_en(id_uses_rs2_en),
    .id_rd_i(id_rd_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_reg_write_en(id_reg_write_en),
    .id_mem_read_en(id_mem_read_en), .id_mem_write_en(id_mem_write_en),
    .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_reg_write_en(ex_reg_write_en),
    .ex_mem_read_en(ex_mem_read_en), .ex_mem_write_en(ex_mem_write_en),
    .ex_ctrl_o(ex_ctrl_o), .stall_if_id_o(stall_if_id_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Directed vector: inputs then expected stall (pre-edge) and post-edge state.
  typedef struct {
    int rst, flush, hold, valid, rs1, rs2, u1, u2, rd, rw, mr, mw;
    int e_stall, e_valid, e_rd, e_rw, e_mr, e_mw, e_bub, e_fl;
  } vec_t;

  typedef struct {
    bit chk_data;
    bit valid, rw, mr, mw;
    logic [4:0] rd, rs1, rs2;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [CTRL_W-1:0] ctrl;
    int bub, fl;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic set_in(input int v, input int rs1, input int rs2, input int u1,
                        input int u2, input int rd, input int rw, input int mr, input int mw);
    id_valid_i = 1'(v);
    id_rs1_i = 5'(rs1);
    id_rs2_i = 5'(rs2);
    id_uses_rs1_en = 1'(u1);
    id_uses_rs2_en = 1'(u2);
    id_rd_i = 5'(rd);
    id_reg_write_en = 1'(rw);
    id_mem_read_en = 1'(mr);
    id_mem_write_en = 1'(mw);
  endtask

  task automatic pop_cmp();
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    n_cmp--;
    e = sbq.pop_front();
    chk("ex_valid", ex_valid_o, e.valid);
    chk("ex_reg_write", ex_reg_write_en, e.rw);
    chk("ex_mem_read", ex_mem_read_en, e.mr);
    chk("ex_mem_write", ex_mem_write_en, e.mw);
    chk("bubble_cnt", bubble_cnt_o, e.bub);
    chk("flush_cnt", flush_cnt_o, e.fl);
    if (e.valid || e.chk_data) chk("ex_rd", ex_rd_o, e.rd);
    if (e.chk_data) begin
      chk("ex_pc", ex_pc_o, e.pc);
      chk("ex_rs1", ex_rs1_o, e.rs1);
      chk("ex_rs2", ex_rs2_o, e.rs2);
      chk("ex_rs1_data", ex_rs1_data_o, e.d1);
      chk("ex_rs2_data", ex_rs2_data_o, e.d2);
      chk("ex_imm", ex_imm_o, e.imm);
      chk("ex_ctrl", ex_ctrl_o, e.ctrl);
    end
  endtask

  task automatic do_cycle(input bit e_stall);
    #1;
    chk("stall_if_id", stall_if_id_o, e_stall);
    @(posedge clk_i);
    #1;
    pop_cmp();
  endtask

  task automatic push_simple(input int v, input int rd, input int rw, input int mr,
                             input int mw, input int bub, input int fl);
    exp_t e;
    e = '{default: '0};
    e.valid = 1'(v); e.rd = 5'(rd); e.rw = 1'(rw); e.mr = 1'(mr); e.mw = 1'(mw);
    e.bub = bub; e.fl = fl;
    sbq.push_back(e);
  endtask

  task automatic run_vec(input vec_t r);
    @(negedge clk_i);
    rst_i = 1'(r.rst); flush_i = 1'(r.flush); hold_i = 1'(r.hold);
    set_in(r.valid, r.rs1, r.rs2, r.u1, r.u2, r.rd, r.rw, r.mr, r.mw);
    id_pc_i = id_pc_i + 32'd4;
    push_simple(r.e_valid, r.e_rd, r.e_rw, r.e_mr, r.e_mw, r.e_bub, r.e_fl);
    do_cycle(1'(r.e_stall));
  endtask

  // Random-stream model state
  exp_t m;
  bit mu1, mu2;
  bit mem_v, mem_mr, mem_rw;
  logic [4:0] mem_rd;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required completion within budget");
    $fatal(1, "timeout");
  end

  initial begin
    int bub;
    bit need_new, lu, e_stall, haz;
    exp_t e;

    rst_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_pc_i = 32'h1000; id_rs1_data_i = 32'h1111_0000; id_rs2_data_i = 32'h2222_0000;
    id_imm_i = 32'h0000_0abc; id_ctrl_i = 8'h5a;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset ex_valid", ex_valid_o, 0);
    chk("reset enables", {ex_reg_write_en, ex_mem_read_en, ex_mem_write_en}, 0);
    chk("reset ex_pc", ex_pc_o, 0);
    chk("reset ex_rd", ex_rd_o, 0);
    chk("reset ex_ctrl", ex_ctrl_o, 0);
    chk("reset counters", {bubble_cnt_o, flush_cnt_o}, 0);
    chk("reset stall", stall_if_id_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // rst flush hold | valid rs1 rs2 u1 u2 rd rw mr mw | stall valid rd rw mr mw bub fl
    tbl.push_back('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, 0,0}); // lw x5
    tbl.push_back('{0,0,0, 1,5,1,1,1,6,1,0,0, 1,0,0,0,0,0, 1,0}); // add x6,x5,x1 stalls
    tbl.push_back('{0,0,0, 1,5,1,1,1,6,1,0,0, 0,1,6,1,0,0, 1,0}); // re-presented add
    tbl.push_back('{0,0,0, 1,1,0,1,0,0,1,1,0, 0,1,0,1,1,0, 1,0}); // lw x0
    tbl.push_back('{0,0,0, 1,0,0,1,1,6,1,0,0, 0,1,6,1,0,0, 1,0}); // reads x0: no stall
    tbl.push_back('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, 1,0}); // lw x5
    tbl.push_back('{0,0,0, 1,5,5,0,0,5,1,0,0, 0,1,5,1,0,0, 1,0}); // lui x5: no stall
    tbl.push_back('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, 1,0}); // lw x5
    tbl.push_back('{0,1,0, 1,5,1,1,1,6,1,0,0, 0,0,0,0,0,0, 1,1}); // load_use + flush
    tbl.push_back('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, 1,1}); // lw x5
    tbl.push_back('{0,0,1, 1,5,1,1,1,6,1,0,0, 0,1,5,1,1,0, 1,1}); // hold x3
    tbl.push_back('{0,0,1, 1,5,1,1,1,6,1,0,0, 0,1,5,1,1,0, 1,1});
    tbl.push_back('{0,0,1, 1,5,1,1,1,6,1,0,0, 0,1,5,1,1,0, 1,1});
    tbl.push_back('{0,0,0, 1,5,1,1,1,6,1,0,0, 1,0,0,0,0,0, 2,1}); // released: stall
    tbl.push_back('{0,0,0, 1,5,1,1,1,6,1,0,0, 0,1,6,1,0,0, 2,1});
    tbl.push_back('{0,0,0, 1,2,3,1,1,0,0,0,1, 0,1,0,0,0,1, 2,1}); // sw
    tbl.push_back('{0,1,0, 0,1,0,1,0,5,1,1,0, 0,0,0,0,0,0, 2,1}); // flush of invalid slot
    tbl.push_back('{0,0,0, 0,1,0,1,0,5,1,1,0, 0,0,0,0,0,0, 2,1}); // invalid: enables gated
    tbl.push_back('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, 2,1}); // lw x5
    tbl.push_back('{0,0,0, 1,1,5,1,1,7,1,0,0, 1,0,0,0,0,0, 3,1}); // rs2 dependency
    tbl.push_back('{0,1,1, 1,1,5,1,1,7,1,0,0, 0,0,0,0,0,0, 3,1}); // hold beats flush
    tbl.push_back('{0,0,0, 1,1,5,1,1,7,1,0,0, 0,1,7,1,0,0, 3,1});
    foreach (tbl[i]) run_vec(tbl[i]);

    // Saturation: 17 more bubbles drive bubble_cnt to all-ones and keep it there.
    bub = 3;
    for (int k = 0; k < 17; k++) begin
      run_vec('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, bub,1});
      bub = sat(bub);
      run_vec('{0,0,0, 1,5,1,1,1,6,1,0,0, 1,0,0,0,0,0, bub,1});
    end
    chk("bubble saturated", bubble_cnt_o, CMAX);

    // Reset pulse while a stall is pending clears everything.
    run_vec('{0,0,0, 1,1,0,1,0,5,1,1,0, 0,1,5,1,1,0, CMAX,1});
    @(negedge clk_i);
    rst_i = 1'b1;
    set_in(1, 5, 1, 1, 1, 6, 1, 0, 0);
    e = '{default: '0};
    e.chk_data = 1'b1;
    sbq.push_back(e);
    do_cycle(1'b1);
    run_vec('{0,0,0, 1,5,1,1,1,6,1,0,0, 0,1,6,1,0,0, 0,0});

    // Random stream against a reference model.
    m = '{default: '0};
    m.valid = 1'b1; m.rd = 5'd6; m.rw = 1'b1; m.rs1 = 5'd5; m.rs2 = 5'd1;
    m.pc = id_pc_i; m.d1 = id_rs1_data_i; m.d2 = id_rs2_data_i;
    m.imm = id_imm_i; m.ctrl = id_ctrl_i;
    mu1 = 1'b1; mu2 = 1'b1;
    mem_v = 1'b0; mem_mr = 1'b0; mem_rw = 1'b0; mem_rd = '0;
    need_new = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0;
      if (need_new) begin
        case ($urandom_range(0, 2))
          0: set_in(1, $urandom_range(0, 7), 0, 1, 0, $urandom_range(0, 7), 1, 1, 0);
          1: set_in(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, 1,
                    $urandom_range(0, 7), 1, 0, 0);
          default: set_in(1, $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 7), $urandom_range(0, 1), 0,
                          $urandom_range(0, 1));
        endcase
        id_valid_i = ($urandom_range(0, 9) != 0);
        id_pc_i = id_pc_i + 32'd4;
        id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
        id_ctrl_i = 8'($urandom);
      end
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i = ($urandom_range(0, 9) == 0);
      lu = m.valid & m.mr & m.rw & (m.rd != 0) & id_valid_i &
           ((id_uses_rs1_en & (id_rs1_i == m.rd)) | (id_uses_rs2_en & (id_rs2_i == m.rd)));
      e_stall = lu & ~flush_i & ~hold_i;
      if (!hold_i) begin
        mem_v = m.valid; mem_mr = m.mr; mem_rw = m.rw; mem_rd = m.rd;
        if (flush_i) begin
          m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
          if (id_valid_i) m.fl = sat(m.fl);
        end else if (lu) begin
          m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
          m.bub = sat(m.bub);
        end else begin
          m.valid = id_valid_i; m.pc = id_pc_i; m.rs1 = id_rs1_i; m.rs2 = id_rs2_i;
          m.rd = id_rd_i; m.d1 = id_rs1_data_i; m.d2 = id_rs2_data_i; m.imm = id_imm_i;
          m.ctrl = id_ctrl_i;
          m.rw = id_reg_write_en & id_valid_i;
          m.mr = id_mem_read_en & id_valid_i;
          m.mw = id_mem_write_en & id_valid_i;
          mu1 = id_uses_rs1_en; mu2 = id_uses_rs2_en;
        end
      end
      e = m;
      e.chk_data = m.valid;
      sbq.push_back(e);
      need_new = !(hold_i || e_stall);
      do_cycle(e_stall);
      if (!hold_i) begin
        haz = ex_valid_o & mem_v & mem_mr & mem_rw & (mem_rd != 0) &
              ((mu1 & (ex_rs1_o == mem_rd)) | (mu2 & (ex_rs2_o == mem_rd)));
        chk("load consumer in EX", haz, 0);
      end
    end

    chk("scoreboard drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
